motor_ramp_ctrl: RTL and testbench
==================================

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter SIZE, default 16: width of the signed power command and output.
REQ-002 Parameter STEP, default 8: maximum power change per ramp tick.
REQ-003 Parameter TICK_DIV, default 100_000: clk cycles per ramp tick.
REQ-004 Parameter DEAD_TICKS, default 50: ramp ticks held at zero before a direction reversal.
REQ-005 Parameter WDOG_TICKS, default 500: ramp ticks without an accepted command before watchdog trip.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  1  requester presents cmd_power.
REQ-009 cmd_ready  output  1  controller can accept a command.
REQ-010 cmd_power  input  SIZE  signed two's-complement target power.
REQ-011 estop  input  1  emergency stop, level-sensitive.
REQ-012 motor_power  output  SIZE  signed ramped power driving the motor PWM stage.
REQ-013 state  output  2  FSM state: 0 IDLE, 1 RAMP, 2 DWELL, 3 ESTOP.
REQ-014 at_target  output  1  high when motor_power equals the latched target.
REQ-015 wdog_trip  output  1  watchdog has forced the target to zero.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL pulse for one cycle at count TICK_DIV-1; it is free-running and cleared only by reset.
REQ-017 cmd_ready SHALL be high in IDLE, RAMP and DWELL, and low in ESTOP.
REQ-018 A command SHALL be accepted on any cycle with cmd_valid && cmd_ready; target SHALL update on the next cycle.
REQ-019 Accepted cmd_power SHALL be clamped to [-1023, +1023] before latching; -2^(SIZE-1) SHALL clamp to -1023.
REQ-020 Ramp SHALL act only on tick cycles: if |target-motor_power| <= STEP, motor_power <= target; otherwise motor_power moves STEP toward target.
REQ-021 If target sign opposes nonzero motor_power, ramp SHALL approach 0, not target.
REQ-022 IDLE: motor_power 0, target 0; a nonzero accepted target SHALL move to RAMP.
REQ-023 RAMP: on reaching 0 with an opposite-sign nonzero target pending, move to DWELL; on reaching 0 with a zero target, move to IDLE.
REQ-024 Entering RAMP from IDLE SHALL start ramping on the next tick without dwell.
REQ-025 DWELL: motor_power held 0 for DEAD_TICKS ticks, then move to RAMP; a new zero target during DWELL SHALL move to IDLE; a new target sign change during DWELL SHALL restart the dwell count.
REQ-026 Watchdog counter SHALL clear on every accepted command and increment on each tick otherwise, saturating at WDOG_TICKS.
REQ-027 When the watchdog counter reaches WDOG_TICKS, target SHALL be forced to 0 and wdog_trip set; wdog_trip SHALL clear on the cycle after the next accepted command.
REQ-028 estop high in any state SHALL set motor_power to 0 and state to ESTOP on the next clk edge, regardless of tick.
REQ-029 ESTOP: hold while estop high; on estop low go to IDLE with target 0; commands presented during ESTOP are not accepted.
REQ-030 at_target SHALL be combinational: (motor_power == target).
REQ-031 A command accepted on a tick cycle SHALL not affect that tick's ramp step; ramping uses the previously latched target.

Reset
REQ-032 On reset: motor_power 0, target 0, state IDLE, wdog_trip 0, prescaler, dwell and watchdog counters 0; cmd_ready 1 after reset deasserts.
REQ-033 Reset asserted mid-ramp or mid-dwell SHALL take effect immediately without waiting for clk.

Verification (bench params: TICK_DIV=4, STEP=8, DEAD_TICKS=3, WDOG_TICKS=20)
REQ-034 Command +20 from IDLE -> motor_power 8, 16, 20 on three successive ticks; at_target 1 after third; state RAMP.
REQ-035 At +20, command -12 -> 12, 4, 0, state DWELL with 0 for 3 ticks, then -8, -12.
REQ-036 Command +5000 -> target clamped to +1023; motor_power saturates at 1023 after 128 ticks.
REQ-037 Hold at +16, no commands for 20 ticks -> wdog_trip 1, ramp 8, 0, state IDLE; new command clears wdog_trip.
REQ-038 At +16, estop pulse -> motor_power 0 next clk, state ESTOP, cmd_ready 0; estop low -> IDLE, target 0.
REQ-039 Reset asserted mid-dwell between clk edges -> all outputs at reset values immediately.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// Ramped, direction-safe motor power controller: slew-limited power with
// dead time on reversal, command watchdog and level-sensitive emergency stop.
module motor_ramp_ctrl #(
  parameter int SIZE       = 16,
  parameter int STEP       = 8,
  parameter int TICK_DIV   = 100_000,
  parameter int DEAD_TICKS = 50,
  parameter int WDOG_TICKS = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic signed [SIZE-1:0] cmd_power,
  input  logic                   estop,
  output logic signed [SIZE-1:0] motor_power,
  output logic [1:0]             state,
  output logic                   at_target,
  output logic                   wdog_trip
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DWELL = 2'd2,
    ST_ESTOP = 2'd3
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam int WW = (WDOG_TICKS > 0) ? $clog2(WDOG_TICKS + 1) : 1;
  localparam int SW = SIZE + 1;

  localparam logic [PW-1:0]          PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]          DWELL_LAST = DW'(DEAD_TICKS - 1);
  localparam logic [WW-1:0]          WDOG_MAX   = WW'(WDOG_TICKS);
  localparam logic signed [SIZE-1:0] CMD_MAX    = SIZE'(1023);
  localparam logic signed [SIZE-1:0] CMD_MIN    = SIZE'(-1023);
  localparam logic signed [SIZE-1:0] STEP_S     = SIZE'(STEP);
  localparam logic signed [SW-1:0]   STEP_W     = SW'(STEP);
  localparam logic signed [SW-1:0]   NSTEP_W    = SW'(-STEP);

  state_t                 state_reg, state_next;
  logic signed [SIZE-1:0] motor_reg, motor_next;
  logic signed [SIZE-1:0] target_reg, target_next;
  logic [PW-1:0]          presc_reg;
  logic [DW-1:0]          dwell_reg, dwell_next;
  logic [WW-1:0]          wdog_reg, wdog_next;
  logic                   trip_reg, trip_next;

  logic                   tick;
  logic                   accept;
  logic                   opposite;
  logic                   sign_flip;
  logic signed [SIZE-1:0] cmd_clamped;
  logic signed [SIZE-1:0] ramp_goal;
  logic signed [SIZE-1:0] ramp_value;
  logic signed [SW-1:0]   ramp_diff;

  assign tick        = (presc_reg == PRESC_LAST);
  assign cmd_ready   = (state_reg != ST_ESTOP);
  assign accept      = cmd_valid && cmd_ready;
  assign motor_power = motor_reg;
  assign state       = state_reg;
  assign at_target   = (motor_reg == target_reg);
  assign wdog_trip   = trip_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + PW'(1);
  end

  always_comb begin
    cmd_clamped = cmd_power;
    if (cmd_power > CMD_MAX)      cmd_clamped = CMD_MAX;
    else if (cmd_power < CMD_MIN) cmd_clamped = CMD_MIN;
  end

  // A target on the far side of zero only pulls the motor down to zero;
  // the reversal itself happens after the dwell.
  assign opposite  = (motor_reg != '0) && (target_reg != '0) &&
                     (motor_reg[SIZE-1] != target_reg[SIZE-1]);
  assign ramp_goal = opposite ? '0 : target_reg;
  assign ramp_diff = {ramp_goal[SIZE-1], ramp_goal} - {motor_reg[SIZE-1], motor_reg};
  assign sign_flip = accept && (cmd_clamped != '0) &&
                     (cmd_clamped[SIZE-1] != target_reg[SIZE-1]);

  always_comb begin
    ramp_value = ramp_goal;
    if (ramp_diff > STEP_W)       ramp_value = motor_reg + STEP_S;
    else if (ramp_diff < NSTEP_W) ramp_value = motor_reg - STEP_S;
  end

  always_comb begin
    state_next  = state_reg;
    motor_next  = motor_reg;
    target_next = target_reg;
    dwell_next  = dwell_reg;
    wdog_next   = wdog_reg;
    trip_next   = trip_reg;

    if (accept) begin
      wdog_next   = '0;
      trip_next   = 1'b0;
      target_next = cmd_clamped;
    end else begin
      if (tick && (wdog_reg != WDOG_MAX)) wdog_next = wdog_reg + WW'(1);
      if (wdog_reg == WDOG_MAX) begin
        target_next = '0;
        trip_next   = 1'b1;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        motor_next = '0;
        dwell_next = '0;
        if (target_next != '0) state_next = ST_RAMP;
      end
      ST_RAMP: begin
        if (tick) begin
          motor_next = ramp_value;
          if (ramp_value == '0) begin
            dwell_next = '0;
            state_next = (target_reg == '0) ? ST_IDLE : ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        motor_next = '0;
        if (target_reg == '0) begin
          state_next = ST_IDLE;
          dwell_next = '0;
        end else if (sign_flip) begin
          dwell_next = '0;
        end else if (tick) begin
          if (dwell_reg == DWELL_LAST) begin
            state_next = ST_RAMP;
            dwell_next = '0;
          end else begin
            dwell_next = dwell_reg + DW'(1);
          end
        end
      end
      ST_ESTOP: begin
        motor_next  = '0;
        target_next = '0;
        dwell_next  = '0;
        if (!estop) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Emergency stop overrides everything, independent of the ramp tick.
    if (estop) begin
      state_next  = ST_ESTOP;
      motor_next  = '0;
      target_next = '0;
      dwell_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      motor_reg  <= '0;
      target_reg <= '0;
      dwell_reg  <= '0;
      wdog_reg   <= '0;
      trip_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      motor_reg  <= motor_next;
      target_reg <= target_next;
      dwell_reg  <= dwell_next;
      wdog_reg   <= wdog_next;
      trip_reg   <= trip_next;
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenario tasks plus a randomized run
// against a behavioural integer model of the ramp/dwell/watchdog rules.
module tb_motor_ramp_ctrl;

  localparam int SIZE       = 16;
  localparam int STEP       = 8;
  localparam int TICK_DIV   = 4;
  localparam int DEAD_TICKS = 3;
  localparam int WDOG_TICKS = 20;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic signed [SIZE-1:0] cmd_power = '0;
  logic                   estop = 1'b0;
  logic                   cmd_ready;
  logic signed [SIZE-1:0] motor_power;
  logic [1:0]             state;
  logic                   at_target;
  logic                   wdog_trip;

  int n_vec = 0;
  int n_err = 0;
  int ecount;
  logic signed [SIZE-1:0] exp_p;

  // behavioural model state (plain integers)
  int m_state, m_motor, m_target, m_presc, m_left, m_since, m_trip;

  motor_ramp_ctrl #(
    .SIZE(SIZE), .STEP(STEP), .TICK_DIV(TICK_DIV),
    .DEAD_TICKS(DEAD_TICKS), .WDOG_TICKS(WDOG_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_power(cmd_power), .estop(estop), .motor_power(motor_power),
    .state(state), .at_target(at_target), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  // clock edges since reset release; tick edges are multiples of TICK_DIV
  always @(posedge clk or posedge reset) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int clamp_cmd(input int v);
    if (v > 1023)  return 1023;
    if (v < -1023) return -1023;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int approach(input int from, input int to);
    if (to - from > STEP) return from + STEP;
    if (from - to > STEP) return from - STEP;
    return to;
  endfunction

  task automatic model_reset();
    m_state = 0; m_motor = 0; m_target = 0; m_presc = 0;
    m_left = 0; m_since = 0; m_trip = 0;
  endtask

  // One clock edge of the rules, given the inputs present before the edge.
  task automatic model_step(input bit v, input int p, input bit e);
    bit tk, acc;
    int c, goal, n_state, n_motor, n_target, n_left, n_since, n_trip;
    tk = (m_presc == TICK_DIV - 1);
    acc = v && (m_state != 3);
    c = clamp_cmd(p);
    n_state = m_state; n_motor = m_motor; n_target = m_target;
    n_left = m_left; n_since = m_since; n_trip = m_trip;
    if (acc) begin
      n_since = 0; n_trip = 0; n_target = c;
    end else begin
      if (tk) n_since = m_since + 1;
      if (m_since >= WDOG_TICKS) begin n_target = 0; n_trip = 1; end
    end
    if (e) begin
      n_state = 3; n_motor = 0; n_target = 0;
    end else begin
      case (m_state)
        0: begin n_motor = 0; if (n_target != 0) n_state = 1; end
        1: if (tk) begin
             goal = (sgn(m_target) * sgn(m_motor) < 0) ? 0 : m_target;
             n_motor = approach(m_motor, goal);
             if (n_motor == 0) begin
               n_state = (m_target == 0) ? 0 : 2;
               n_left = DEAD_TICKS;
             end
           end
        2: begin
             if (m_target == 0) n_state = 0;
             else if (acc && c != 0 && sgn(c) != sgn(m_target)) n_left = DEAD_TICKS;
             else if (tk) begin
               n_left = m_left - 1;
               if (n_left == 0) n_state = 1;
             end
           end
        default: begin n_state = 0; n_motor = 0; n_target = 0; end
      endcase
    end
    m_presc = (m_presc + 1) % TICK_DIV;
    m_state = n_state; m_motor = n_motor; m_target = n_target;
    m_left = n_left; m_since = n_since; m_trip = n_trip;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_power = '0; estop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_tick();
    @(posedge clk); #1;
    for (int i = 0; i < TICK_DIV && (ecount % TICK_DIV) != 0; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_cmd(input int p);
    cmd_valid = 1'b1;
    cmd_power = SIZE'(p);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("txn cmd_power=%0d edge=%0d motor_power=%0d state=%0d", p, ecount, motor_power, state);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (motor_power !== '0) begin n_err++; $display("FAIL reset_motor got %0d exp 0", motor_power); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reset_at_target got %b exp 1", at_target); end
    n_vec++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL reset_wdog got %b exp 0", wdog_trip); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_ramp_up();
    int exp_m[3] = '{8, 16, 20};
    do_reset();
    send_cmd(20);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL rampup_enter got %0d exp 1", state); end
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      exp_p = SIZE'(exp_m[i]);
      n_vec++; if (motor_power !== exp_p) begin n_err++; $display("FAIL rampup_tick%0d got %0d exp %0d", i, motor_power, exp_p); end
    end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL rampup_at_target got %b exp 1", at_target); end
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL rampup_state got %0d exp 1", state); end
  endtask

  task automatic test_reversal();
    int exp_m[8] = '{12, 4, 0, 0, 0, 0, -8, -12};
    int exp_s[8] = '{1, 1, 2, 2, 2, 1, 1, 1};
    send_cmd(-12);
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL rev_state0 got %0d exp 1", state); end
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      exp_p = SIZE'(exp_m[i]);
      n_vec++; if (motor_power !== exp_p) begin n_err++; $display("FAIL rev_motor_t%0d got %0d exp %0d", i, motor_power, exp_p); end
      n_vec++; if (int'(state) != exp_s[i]) begin n_err++; $display("FAIL rev_state_t%0d got %0d exp %0d", i, state, exp_s[i]); end
    end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL rev_at_target got %b exp 1", at_target); end
  endtask

  task automatic test_clamp(input int cmd, input int lim);
    int sg;
    sg = (lim > 0) ? 1 : -1;
    do_reset();
    send_cmd(cmd);
    for (int t = 1; t <= 129; t++) begin
      wait_tick();
      if (t == 127) begin
        exp_p = SIZE'(sg * 1016);
        n_vec++; if (motor_power !== exp_p) begin n_err++; $display("FAIL clamp%0d_t127 got %0d exp %0d", lim, motor_power, exp_p); end
        n_vec++; if (at_target !== 1'b0) begin n_err++; $display("FAIL clamp%0d_at127 got %b exp 0", lim, at_target); end
      end
      if (t >= 128) begin
        exp_p = SIZE'(lim);
        n_vec++; if (motor_power !== exp_p) begin n_err++; $display("FAIL clamp%0d_t%0d got %0d exp %0d", lim, t, motor_power, exp_p); end
        n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL clamp%0d_at%0d got %b exp 1", lim, t, at_target); end
      end
      if (t % 8 == 0) send_cmd(cmd);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    send_cmd(16);
    for (int t = 1; t <= 20; t++) wait_tick();
    n_vec++; if (motor_power !== 16'sd16) begin n_err++; $display("FAIL wdog_hold got %0d exp 16", motor_power); end
    n_vec++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_early got %b exp 0", wdog_trip); end
    wait_tick();
    n_vec++; if (wdog_trip !== 1'b1) begin n_err++; $display("FAIL wdog_trip got %b exp 1", wdog_trip); end
    n_vec++; if (motor_power !== 16'sd8) begin n_err++; $display("FAIL wdog_ramp8 got %0d exp 8", motor_power); end
    wait_tick();
    n_vec++; if (motor_power !== 16'sd0) begin n_err++; $display("FAIL wdog_ramp0 got %0d exp 0", motor_power); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL wdog_idle got %0d exp 0", state); end
    n_vec++; if (wdog_trip !== 1'b1) begin n_err++; $display("FAIL wdog_held got %b exp 1", wdog_trip); end
    send_cmd(30);
    n_vec++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_clear got %b exp 0", wdog_trip); end
    n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL wdog_rearm got %0d exp 1", state); end
  endtask

  task automatic test_estop();
    do_reset();
    send_cmd(16);
    wait_tick(); wait_tick();
    n_vec++; if (motor_power !== 16'sd16) begin n_err++; $display("FAIL estop_pre got %0d exp 16", motor_power); end
    estop = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (motor_power !== 16'sd0) begin n_err++; $display("FAIL estop_motor got %0d exp 0", motor_power); end
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL estop_state got %0d exp 3", state); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL estop_ready got %b exp 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_power = 16'sd40;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL estop_hold got %0d exp 3", state); end
    estop = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL estop_exit got %0d exp 0", state); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL estop_target0 got %b exp 1", at_target); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL estop_ready1 got %b exp 1", cmd_ready); end
    wait_tick();
    n_vec++; if (motor_power !== 16'sd0) begin n_err++; $display("FAIL estop_norun got %0d exp 0", motor_power); end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_cmd(100);
    wait_tick(); wait_tick(); wait_tick();
    n_vec++; if (motor_power !== 16'sd24) begin n_err++; $display("FAIL areset_pre got %0d exp 24", motor_power); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (motor_power !== 16'sd0) begin n_err++; $display("FAIL areset_ramp_motor got %0d exp 0", motor_power); end
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL areset_ramp_state got %0d exp 0", state); end
    do_reset();
    send_cmd(16);
    wait_tick(); wait_tick();
    send_cmd(-16);
    wait_tick(); wait_tick(); wait_tick();
    n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL areset_dwell_pre got %0d exp 2", state); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL areset_dwell_state got %0d exp 0", state); end
    n_vec++; if (at_target !== 1'b1) begin n_err++; $display("FAIL areset_dwell_at got %b exp 1", at_target); end
    n_vec++; if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL areset_dwell_wdog got %b exp 0", wdog_trip); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL areset_dwell_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_random();
    int estop_left, r, sel, div;
    estop_left = 0;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 6000 && n_err < 20; cyc++) begin
      div = (cyc < 3000) ? 30 : 150;
      if (estop_left > 0) begin
        estop = 1'b1; estop_left--;
      end else begin
        estop = 1'b0;
        if ($urandom_range(0, 299) == 0) estop_left = int'($urandom_range(1, 6));
      end
      cmd_valid = ($urandom_range(0, div - 1) == 0);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: r = 0;
        1: r = -32768;
        2: r = 32767;
        3: r = int'($urandom_range(0, 65535)) - 32768;
        default: r = int'($urandom_range(0, 200)) - 100;
      endcase
      cmd_power = SIZE'(r);
      if (cmd_valid && cmd_ready)
        $display("txn rnd cycle=%0d cmd_power=%0d estop=%b", cyc, r, estop);
      model_step(cmd_valid, int'(cmd_power), estop);
      @(posedge clk); #1;
      exp_p = SIZE'(m_motor);
      n_vec++; if (motor_power !== exp_p) begin n_err++; $display("FAIL rnd_motor c%0d got %0d exp %0d", cyc, motor_power, exp_p); end
      n_vec++; if (int'(state) != m_state) begin n_err++; $display("FAIL rnd_state c%0d got %0d exp %0d", cyc, state, m_state); end
      n_vec++; if (at_target !== (m_motor == m_target)) begin n_err++; $display("FAIL rnd_at_target c%0d got %b exp %b", cyc, at_target, (m_motor == m_target)); end
      n_vec++; if (wdog_trip !== (m_trip != 0)) begin n_err++; $display("FAIL rnd_wdog c%0d got %b exp %0d", cyc, wdog_trip, m_trip); end
      n_vec++; if (cmd_ready !== (m_state != 3)) begin n_err++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, cmd_ready, (m_state != 3)); end
    end
    cmd_valid = 1'b0; estop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_clamp(5000, 1023);
    test_clamp(-32768, -1023);
    test_watchdog();
    test_estop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
